// File: rtl/snac_pkg.sv
// Shared types and constants for the SNAC DB15 joystick reader.
// Optional build macro in this slice: SNAC_DEBOUNCE_EN (see snac_db15_reader.sv).
package snac_pkg;

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        SHIFT_LO,
        SHIFT_HI,
        DONE
    } snac_state_e;

    localparam int FRAME_BITS  = 24;
    localparam int PLAYER_BITS = 12;

    localparam int BIT_RIGHT  = 0;
    localparam int BIT_LEFT   = 1;
    localparam int BIT_DOWN   = 2;
    localparam int BIT_UP     = 3;
    localparam int BIT_B1     = 4;
    localparam int BIT_B2     = 5;
    localparam int BIT_B3     = 6;
    localparam int BIT_B4     = 7;
    localparam int BIT_SELECT = 8;
    localparam int BIT_START  = 9;
    localparam int BIT_COIN   = 10;
    localparam int BIT_MODE   = 11;

    // Widen a 12-bit player field to the 16-bit joystick word; top nibble unused.
    function automatic logic [15:0] player_word(input logic [PLAYER_BITS-1:0] bits);
        return {4'b0000, bits};
    endfunction

endpackage

// File: rtl/snac_tick_gen.sv
// Free-running divider: one-clk tick every CLK_DIV clocks, asserted on wrap.
module snac_tick_gen #(
    parameter int CLK_DIV = 48
) (
    input  logic clk,
    input  logic rst_n,
    output logic tick
);

    localparam int CW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(CLK_DIV - 1);

    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;

    always_comb begin
        tick  = (cnt_q == CNT_LAST);
        cnt_d = tick ? '0 : cnt_q + CW'(1);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/snac_db15_reader.sv
// SNAC DB15 reader: drives JOY_LOAD/JOY_CLK, deserialises 24 active-low bits per frame.
// Build macro SNAC_DEBOUNCE_EN: outputs load only when two consecutive frames agree.
module snac_db15_reader
    import snac_pkg::*;
#(
    parameter int CLK_DIV   = 48,
    parameter int GAP_TICKS = 1000
) (
    input  logic        clk,
    input  logic        RESET_N,
    input  logic        en,
    input  logic        JOY_DATA,
    output logic        JOY_CLK,
    output logic        JOY_LOAD,
    output logic [15:0] joystick1,
    output logic [15:0] joystick2,
    output logic        frame_valid
);

    localparam int GW = (GAP_TICKS > 1) ? $clog2(GAP_TICKS) : 1;
    localparam logic [GW-1:0] GAP_LAST = GW'(GAP_TICKS - 1);
    localparam logic [4:0]    BIT_LAST = 5'(FRAME_BITS - 1);

    logic tick;

    snac_tick_gen #(.CLK_DIV(CLK_DIV)) u_tick_gen (
        .clk   (clk),
        .rst_n (RESET_N),
        .tick  (tick)
    );

    snac_state_e             state_q, state_d;
    logic [GW-1:0]           gap_q, gap_d;
    logic [4:0]              bit_q, bit_d;
    logic [FRAME_BITS-1:0]   raw_q, raw_d;
    logic [PLAYER_BITS-1:0]  j1_q, j1_d;
    logic [PLAYER_BITS-1:0]  j2_q, j2_d;
    logic                    fv_q, fv_d;
    logic                    joy_clk_q, joy_clk_d;
    logic                    joy_load_q, joy_load_d;
    logic                    sync1_q, sync2_q;
`ifdef SNAC_DEBOUNCE_EN
    logic [FRAME_BITS-1:0]   prev_q, prev_d;
`endif

    always_comb begin
        state_d = state_q;
        gap_d   = gap_q;
        bit_d   = bit_q;
        raw_d   = raw_q;
        j1_d    = j1_q;
        j2_d    = j2_q;
        fv_d    = 1'b0;
`ifdef SNAC_DEBOUNCE_EN
        prev_d  = prev_q;
`endif
        // Disable wins over every state; DONE is checked too since it is not tick-gated.
        if (!en && (tick || state_q == DONE)) begin
            state_d = IDLE;
            gap_d   = '0;
            bit_d   = '0;
            j1_d    = '0;
            j2_d    = '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (tick) begin
                        if (gap_q == GAP_LAST) begin
                            gap_d   = '0;
                            state_d = LOAD;
                        end else begin
                            gap_d = gap_q + GW'(1);
                        end
                    end
                end
                LOAD: begin
                    if (tick) begin
                        bit_d   = '0;
                        state_d = SHIFT_LO;
                    end
                end
                SHIFT_LO: begin
                    if (tick) begin
                        raw_d[bit_q] = ~sync2_q;
                        state_d      = SHIFT_HI;
                    end
                end
                SHIFT_HI: begin
                    if (tick) begin
                        if (bit_q == BIT_LAST) begin
                            state_d = DONE;
                        end else begin
                            bit_d   = bit_q + 5'd1;
                            state_d = SHIFT_LO;
                        end
                    end
                end
                DONE: begin
                    state_d = IDLE;
                    bit_d   = '0;
`ifdef SNAC_DEBOUNCE_EN
                    prev_d = raw_q;
                    if (raw_q == prev_q) begin
                        j1_d = raw_q[PLAYER_BITS-1:0];
                        j2_d = raw_q[FRAME_BITS-1:PLAYER_BITS];
                        fv_d = 1'b1;
                    end
`else
                    j1_d = raw_q[PLAYER_BITS-1:0];
                    j2_d = raw_q[FRAME_BITS-1:PLAYER_BITS];
                    fv_d = 1'b1;
`endif
                end
                default: state_d = IDLE;
            endcase
        end
        // Adapter strobes are registered from the next state so they never glitch.
        joy_clk_d  = (state_d != SHIFT_LO);
        joy_load_d = (state_d != LOAD);
    end

    always_ff @(posedge clk or negedge RESET_N) begin
        if (!RESET_N) begin
            state_q    <= IDLE;
            gap_q      <= '0;
            bit_q      <= '0;
            raw_q      <= '0;
            j1_q       <= '0;
            j2_q       <= '0;
            fv_q       <= 1'b0;
            joy_clk_q  <= 1'b1;
            joy_load_q <= 1'b1;
            sync1_q    <= 1'b1;
            sync2_q    <= 1'b1;
`ifdef SNAC_DEBOUNCE_EN
            prev_q     <= '0;
`endif
        end else begin
            state_q    <= state_d;
            gap_q      <= gap_d;
            bit_q      <= bit_d;
            raw_q      <= raw_d;
            j1_q       <= j1_d;
            j2_q       <= j2_d;
            fv_q       <= fv_d;
            joy_clk_q  <= joy_clk_d;
            joy_load_q <= joy_load_d;
            sync1_q    <= JOY_DATA;
            sync2_q    <= sync1_q;
`ifdef SNAC_DEBOUNCE_EN
            prev_q     <= prev_d;
`endif
        end
    end

    assign JOY_CLK     = joy_clk_q;
    assign JOY_LOAD    = joy_load_q;
    assign joystick1   = player_word(j1_q);
    assign joystick2   = player_word(j2_q);
    assign frame_valid = fv_q;

endmodule

// File: tb/tb_snac_db15_reader.sv
// Directed bench for snac_db15_reader with a 74HC165-style adapter model.
module tb_snac_db15_reader;

    localparam int DIV        = 4;
    localparam int GAP        = 20;
    localparam int FRAME_CLK  = (GAP + 49) * DIV;
    localparam int WAIT_LIMIT = 3 * FRAME_CLK;

    logic        clk = 1'b0;
    logic        RESET_N = 1'b0;
    logic        en = 1'b0;
    logic        JOY_DATA;
    logic        JOY_CLK;
    logic        JOY_LOAD;
    logic [15:0] joystick1;
    logic [15:0] joystick2;
    logic        frame_valid;

    always #5 clk = ~clk;

    snac_db15_reader #(.CLK_DIV(DIV), .GAP_TICKS(GAP)) dut (
        .clk         (clk),
        .RESET_N     (RESET_N),
        .en          (en),
        .JOY_DATA    (JOY_DATA),
        .JOY_CLK     (JOY_CLK),
        .JOY_LOAD    (JOY_LOAD),
        .joystick1   (joystick1),
        .joystick2   (joystick2),
        .frame_valid (frame_valid)
    );

    // Adapter: bit k of adapter_word (active low) appears after k JOY_CLK rises.
    logic [23:0] adapter_word = '1;
    logic [23:0] sr = '1;
    always @(negedge JOY_LOAD or posedge JOY_CLK) begin
        if (!JOY_LOAD) sr <= adapter_word;
        else           sr <= {1'b1, sr[23:1]};
    end
    assign JOY_DATA = sr[0];

    int cyc = 0;
    always @(posedge clk) begin
        if (!RESET_N) cyc <= 0;
        else          cyc <= cyc + 1;
    end

    logic prev_load = 1'b1;
    logic prev_clk  = 1'b1;
    int load_fall_cyc = 0, load_len = 0, n_load_falls = 0;
    int clk_fall_cyc = 0, n_clk_falls = 0, n_clk_rises = 0, n_bad_width = 0;
    int n_fv = 0, fv_cyc = 0;

    always @(negedge clk) begin
        prev_load <= JOY_LOAD;
        prev_clk  <= JOY_CLK;
        if (RESET_N) begin
            if (prev_load && !JOY_LOAD) begin
                load_fall_cyc <= cyc;
                n_load_falls  <= n_load_falls + 1;
            end
            if (!prev_load && JOY_LOAD) load_len <= cyc - load_fall_cyc;
            if (prev_clk && !JOY_CLK) begin
                clk_fall_cyc <= cyc;
                n_clk_falls  <= n_clk_falls + 1;
            end
            if (!prev_clk && JOY_CLK) begin
                n_clk_rises <= n_clk_rises + 1;
                if (cyc - clk_fall_cyc != DIV) n_bad_width <= n_bad_width + 1;
            end
            if (frame_valid) begin
                n_fv   <= n_fv + 1;
                fv_cyc <= cyc;
            end
        end
    end

    int n_checks = 0;
    int n_err    = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got=%h expected=%h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(negedge clk);
        #1;
    endtask

    task automatic wait_fv();
        int start;
        bit seen;
        start = n_fv;
        seen  = 1'b0;
        for (int i = 0; i < WAIT_LIMIT && !seen; i++) begin
            step();
            if (n_fv != start) seen = 1'b1;
        end
        if (!seen) check("fv_timeout", n_fv - start, 1);
    endtask

    task automatic wait_falls(input int target);
        bit seen;
        seen = 1'b0;
        for (int i = 0; i < WAIT_LIMIT && !seen; i++) begin
            step();
            if (n_clk_falls >= target) seen = 1'b1;
        end
        if (!seen) check("clk_fall_timeout", n_clk_falls, target);
    endtask

    task automatic wait_rises(input int target);
        bit seen;
        seen = 1'b0;
        for (int i = 0; i < WAIT_LIMIT && !seen; i++) begin
            step();
            if (n_clk_rises >= target) seen = 1'b1;
        end
        if (!seen) check("clk_rise_timeout", n_clk_rises, target);
    endtask

    function automatic logic [23:0] wire_word(input logic [11:0] p1, input logic [11:0] p2);
        return {p2, p1};
    endfunction

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int r0, f0, fv0, l0, c0, exp_load;

        // Reset values
        en = 1'b1;
        repeat (3) step();
        check("rst_joy_clk", JOY_CLK, 1);
        check("rst_joy_load", JOY_LOAD, 1);
        check("rst_j1", joystick1, 16'h0000);
        check("rst_j2", joystick2, 16'h0000);
        check("rst_fv", frame_valid, 0);

        // Frame 1: all released, frame timing
        r0 = n_clk_rises;
        RESET_N = 1'b1;
        wait_fv();
        check("load_fall", load_fall_cyc, GAP * DIV);
        check("load_len", load_len, DIV);
        check("clk_pulses", n_clk_rises - r0, 24);
        check("clk_width_bad", n_bad_width, 0);
        check("fv_cyc", fv_cyc, FRAME_CLK + 1);
        check("f1_j1", joystick1, 16'h0000);
        check("f1_j2", joystick2, 16'h0000);
        step();
        check("fv_one_clk", frame_valid, 0);

        // Frame 2: P1 right pressed
        adapter_word = wire_word(12'hFFE, 12'hFFF);
        wait_fv();
        check("load_fall2", load_fall_cyc, FRAME_CLK + GAP * DIV);
        check("f2_j1", joystick1, 16'h0001);
        check("f2_j2", joystick2, 16'h0000);

        // Frame 3: P1 B1, P2 start; outputs hold until DONE
        adapter_word = wire_word(12'hFEF, 12'hDFF);
        f0 = n_clk_falls;
        wait_falls(f0 + 24);
        check("hold_j1", joystick1, 16'h0001);
        check("hold_j2", joystick2, 16'h0000);
        wait_fv();
        check("f3_j1", joystick1, 16'h0010);
        check("f3_j2", joystick2, 16'h0200);

        // Frame 4: back to right only
        adapter_word = wire_word(12'hFFE, 12'hFFF);
        wait_fv();
        check("f4_j1", joystick1, 16'h0001);

        // Drop en at bit 10 of the next frame
        f0  = n_clk_falls;
        fv0 = n_fv;
        wait_falls(f0 + 11);
        en = 1'b0;
        repeat (DIV - 1) @(negedge clk);
        #1;
        check("abort_wait_clk", JOY_CLK, 0);
        check("abort_wait_j1", joystick1, 16'h0001);
        step();
        check("abort_joy_clk", JOY_CLK, 1);
        check("abort_joy_load", JOY_LOAD, 1);
        check("abort_j1", joystick1, 16'h0000);
        check("abort_j2", joystick2, 16'h0000);
        l0 = n_load_falls;
        repeat (5 * DIV) step();
        check("abort_no_fv", n_fv - fv0, 0);
        check("abort_no_load", n_load_falls - l0, 0);

        // Re-raise en: full gap before LOAD
        c0 = cyc;
        en = 1'b1;
        exp_load = (c0 / DIV + 1) * DIV + (GAP - 1) * DIV;
        wait_fv();
        check("reen_load_fall", load_fall_cyc, exp_load);
        check("reen_j1", joystick1, 16'h0001);

        // Reset in the middle of SHIFT_LO
        adapter_word = wire_word(12'hFEF, 12'hFFF);
        f0 = n_clk_falls;
        wait_falls(f0 + 6);
        RESET_N = 1'b0;
        #1;
        check("mrst_joy_clk", JOY_CLK, 1);
        check("mrst_joy_load", JOY_LOAD, 1);
        check("mrst_j1", joystick1, 16'h0000);
        check("mrst_j2", joystick2, 16'h0000);
        check("mrst_fv", frame_valid, 0);
        adapter_word = '1;
        repeat (3) step();
        RESET_N = 1'b1;
        wait_fv();
        check("mrst_fv_cyc", fv_cyc, FRAME_CLK + 1);
        check("mrst_post_j1", joystick1, 16'h0000);
        check("mrst_post_j2", joystick2, 16'h0000);

`ifdef SNAC_DEBOUNCE_EN
        // One-frame B2 glitch is filtered out
        fv0 = n_fv;
        r0  = n_clk_rises;
        adapter_word = wire_word(12'hFDF, 12'hFFF);
        wait_rises(r0 + 24);
        adapter_word = '1;
        wait_rises(r0 + 48);
        repeat (3) step();
        check("db_glitch_fv", n_fv - fv0, 0);
        check("db_glitch_j1", joystick1, 16'h0000);
        // Two agreeing frames load
        fv0 = n_fv;
        r0  = n_clk_rises;
        adapter_word = wire_word(12'hFDF, 12'hFFF);
        wait_rises(r0 + 48);
        repeat (3) step();
        check("db_hold_fv", n_fv - fv0, 1);
        check("db_hold_j1", joystick1, 16'h0020);
`endif

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
